// File: rtl/reg_file_pkg.sv
// Shared sizing and payload types for the architectural register file.
package reg_file_pkg;

  // ROB geometry: tags wrap modulo ROB_SIZE.
  localparam int unsigned ROB_SIZE  = 16;
  localparam int unsigned ROB_LOG   = $clog2(ROB_SIZE);

  // Architectural register geometry; x0 is hardwired to zero.
  localparam int unsigned NREG      = 32;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NRD       = 2;

  typedef logic [ROB_LOG-1:0]   rob_tag_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

  localparam reg_idx_t REG_ZERO = '0;

  // Operand lookup response: value is meaningful when !busy, tag when busy.
  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
    word_t    value;
  } rd_resp_t;

endpackage

// File: rtl/reg_file_if.sv
// Issue/commit/operand-read bundle between the core and the register file.
interface reg_file_if;
  import reg_file_pkg::*;

  logic     rdy;
  logic     rob_flush;

  logic     issue_valid;
  reg_idx_t issue_dest;
  rob_tag_t issue_RobId;

  reg_idx_t rs1_index;
  reg_idx_t rs2_index;
  logic     rs1_busy;
  logic     rs2_busy;
  rob_tag_t rs1_tag;
  rob_tag_t rs2_tag;
  word_t    rs1_value;
  word_t    rs2_value;

  logic     commit_enable;
  reg_idx_t commit_index;
  rob_tag_t commit_RobId;
  word_t    commit_value;

  // Core side: drives issue, commit and read indices.
  modport master (
    output rdy, rob_flush,
    output issue_valid, issue_dest, issue_RobId,
    output rs1_index, rs2_index,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_value, rs2_value,
    output commit_enable, commit_index, commit_RobId, commit_value
  );

  // Register file side.
  modport slave (
    input  rdy, rob_flush,
    input  issue_valid, issue_dest, issue_RobId,
    input  rs1_index, rs2_index,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_value, rs2_value,
    input  commit_enable, commit_index, commit_RobId, commit_value
  );

endinterface

// File: rtl/reg_file.sv
// Architectural register file with rename tags and a same-cycle commit bypass.
module reg_file
  import reg_file_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  rf
);

  // Per-register state.
  word_t          value_q [NREG];
  logic [NREG-1:0] busy_q;
  rob_tag_t       tag_q   [NREG];

  // Local copies of the bundle for readability.
  logic     rdy;
  logic     rob_flush;
  logic     issue_valid;
  reg_idx_t issue_dest;
  rob_tag_t issue_tag;
  logic     commit_en;
  reg_idx_t commit_idx;
  rob_tag_t commit_tag;
  word_t    commit_val;

  assign rdy         = rf.rdy;
  assign rob_flush   = rf.rob_flush;
  assign issue_valid = rf.issue_valid;
  assign issue_dest  = rf.issue_dest;
  assign issue_tag   = rf.issue_RobId;
  assign commit_en   = rf.commit_enable;
  assign commit_idx  = rf.commit_index;
  assign commit_tag  = rf.commit_RobId;
  assign commit_val  = rf.commit_value;

  // Commits to x0 are discarded; renames are dropped under flush.
  logic commit_live_c;
  logic rename_live_c;

  assign commit_live_c = commit_en && (commit_idx != REG_ZERO);
  assign rename_live_c = issue_valid && (issue_dest != REG_ZERO) && !rob_flush;

  // Operand lookup: x0 reads zero, a matching commit releases the operand this cycle.
  function automatic rd_resp_t port_read(input reg_idx_t idx);
    rd_resp_t r;
    r.busy  = busy_q[idx];
    r.tag   = tag_q[idx];
    r.value = value_q[idx];
    if (idx == REG_ZERO) begin
      r.busy  = 1'b0;
      r.tag   = '0;
      r.value = '0;
    end else if (commit_en && (commit_idx == idx) && busy_q[idx] &&
                 (tag_q[idx] == commit_tag)) begin
      r.busy  = 1'b0;
      r.value = commit_val;
    end
    return r;
  endfunction

  reg_idx_t rd_index [NRD];
  rd_resp_t rd_resp  [NRD];

  assign rd_index[0] = rf.rs1_index;
  assign rd_index[1] = rf.rs2_index;

  // Both read ports share one lookup function.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rd_resp[p] = port_read(rd_index[p]);
  end

  assign rf.rs1_busy  = rd_resp[0].busy;
  assign rf.rs1_tag   = rd_resp[0].tag;
  assign rf.rs1_value = rd_resp[0].value;
  assign rf.rs2_busy  = rd_resp[1].busy;
  assign rf.rs2_tag   = rd_resp[1].tag;
  assign rf.rs2_value = rd_resp[1].value;

  // Commit writes value; flush clears busy; rename beats a same-cycle release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < int'(NREG); i++) begin
        if (commit_live_c && (commit_idx == reg_idx_t'(i))) begin
          value_q[i] <= commit_val;
        end
        if (rob_flush) begin
          busy_q[i] <= 1'b0;
        end else if (rename_live_c && (issue_dest == reg_idx_t'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= issue_tag;
        end else if (commit_live_c && (commit_idx == reg_idx_t'(i)) &&
                     busy_q[i] && (tag_q[i] == commit_tag)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule
